dmem_lsu: RTL

//  Load/store unit between the datapath and the word-only, async-read data memory (dmem).

---
 rtl/dmem_lsu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit for a word-only, async-read data memory: byte/half/word access with extension,
// same-cycle read-modify-write for sub-word stores, and two-cycle handling of word-straddling accesses.
module dmem_lsu #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [1:0]       size_i,
   input  logic             unsigned_i,
   input  logic [31:0]      addr_i32,
   input  logic [31:0]      wdata_i32,
   output logic [31:0]      rdata_o32,
   output logic             done_o,
   output logic             stall_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o32,
   output logic [31:0]      mem_wdata_o32,
   input  logic [31:0]      mem_rdata_i32,
   output logic [CNT_W-1:0] split_cnt_o
);

   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

   state_t            state_r, state_s;
   logic              we_r, uns_r;
   logic [1:0]        size_r, off_r;
   logic [31:0]       wa4_r, wdata_r, hold_r;
   logic [CNT_W-1:0]  split_cnt_r;

   logic [1:0]        off_s;
   logic [31:0]       wa_s;
   logic              split_s, cap_s, cnt_inc_s;
   logic [7:0]        mask8_s;
   logic [63:0]       data64_s;

   // Lane-enable pattern for an access of the given size starting at lane 0.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Replace the enabled byte lanes of old_w with those of new_w.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
      logic [31:0] bm;
      bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      lane_merge = (old_w & ~bm) | (new_w & bm);
   endfunction

   // Sign- or zero-extend a right-justified load value.
   function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] sz,
                                               input logic uns);
      case (sz)
         2'b00:   extend_load = uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
         2'b01:   extend_load = uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         2'b10:   extend_load = raw;
         default: extend_load = 32'h00000000;
      endcase
   endfunction

   assign off_s   = addr_i32[1:0];
   assign wa_s    = {addr_i32[31:2], 2'b00};
   assign split_s = ((size_i == 2'b01) && (off_s == 2'b11)) ||
                    ((size_i == 2'b10) && (off_s != 2'b00));
   assign split_cnt_o = split_cnt_r;

   // Next-state and datapath: lanes of the access live in an 8-lane window spanning wa and wa+4.
   always_comb begin
      state_s       = state_r;
      mem_we_o      = 1'b0;
      mem_addr_o32  = wa_s;
      mem_wdata_o32 = mem_rdata_i32;
      rdata_o32     = 32'h00000000;
      done_o        = 1'b0;
      stall_o       = 1'b0;
      cap_s         = 1'b0;
      cnt_inc_s     = 1'b0;
      mask8_s       = 8'h00;
      data64_s      = 64'h0;
      case (state_r)
         IDLE: begin
            mask8_s  = {4'b0000, size_mask(size_i)} << off_s;
            data64_s = {32'h00000000, wdata_i32} << {off_s, 3'b000};
            if (!req_i) begin
               done_o = 1'b0;
            end else if (size_i == 2'b11) begin
               done_o = 1'b1;
            end else if (split_s) begin
               stall_o       = 1'b1;
               mem_we_o      = we_i;
               mem_wdata_o32 = lane_merge(mem_rdata_i32, data64_s[31:0], mask8_s[3:0]);
               cap_s         = 1'b1;
               state_s       = SECOND;
            end else begin
               done_o = 1'b1;
               if (we_i) begin
                  mem_we_o      = 1'b1;
                  mem_wdata_o32 = lane_merge(mem_rdata_i32, data64_s[31:0], mask8_s[3:0]);
               end else begin
                  rdata_o32 = extend_load(mem_rdata_i32 >> {off_s, 3'b000}, size_i, unsigned_i);
               end
            end
         end
         SECOND: begin
            mask8_s      = {4'b0000, size_mask(size_r)} << off_r;
            data64_s     = {32'h00000000, wdata_r} << {off_r, 3'b000};
            mem_addr_o32 = wa4_r;
            done_o       = 1'b1;
            cnt_inc_s    = 1'b1;
            state_s      = IDLE;
            if (we_r) begin
               mem_we_o      = 1'b1;
               mem_wdata_o32 = lane_merge(mem_rdata_i32, data64_s[63:32], mask8_s[7:4]);
            end else begin
               rdata_o32 = extend_load(hold_r | (mem_rdata_i32 << {(3'd4 - {1'b0, off_r}), 3'b000}),
                                       size_r, uns_r);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // Reset masks every externally visible action, including a pending second half.
      if (rst_i) begin
         mem_we_o  = 1'b0;
         done_o    = 1'b0;
         stall_o   = 1'b0;
         rdata_o32 = 32'h00000000;
      end else begin
         cnt_inc_s = cnt_inc_s & 1'b1;
      end
   end

   // State register, split-access holding registers and saturating split counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         we_r        <= 1'b0;
         uns_r       <= 1'b0;
         size_r      <= 2'b00;
         off_r       <= 2'b00;
         wa4_r       <= 32'h00000000;
         wdata_r     <= 32'h00000000;
         hold_r      <= 32'h00000000;
         split_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (cap_s) begin
            we_r    <= we_i;
            uns_r   <= unsigned_i;
            size_r  <= size_i;
            off_r   <= off_s;
            wa4_r   <= wa_s + 32'd4;
            wdata_r <= wdata_i32;
            hold_r  <= mem_rdata_i32 >> {off_s, 3'b000};
         end else begin
            hold_r <= hold_r;
         end
         if (cnt_inc_s && (split_cnt_r != {CNT_W{1'b1}})) begin
            split_cnt_r <= split_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            split_cnt_r <= split_cnt_r;
         end
      end
   end

endmodule
